// File: rtl/regfile_wport_arbiter.sv
// Single regfile write-port scheduler: WB has fixed priority, A0/A1 share the
// leftover slots round-robin, and a starvation FSM asks the pipeline to stall.
//
// state  | meaning
// NORMAL | no stall requested; watching aux wait time
// STALL  | stall_req high until an aux is granted or withdraws
module regfile_wport_arbiter #(
   parameter int RegAddrWidth = 5,
   parameter int RegWidth     = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wb_we,
   input  logic [RegAddrWidth-1:0] wb_waddr,
   input  logic [RegWidth-1:0]     wb_wdata,
   input  logic                    a0_valid,
   input  logic [RegAddrWidth-1:0] a0_waddr,
   input  logic [RegWidth-1:0]     a0_wdata,
   output logic                    a0_ready,
   input  logic                    a1_valid,
   input  logic [RegAddrWidth-1:0] a1_waddr,
   input  logic [RegWidth-1:0]     a1_wdata,
   output logic                    a1_ready,
   output logic                    stall_req,
   output logic                    rf_we,
   output logic [RegAddrWidth-1:0] rf_waddr,
   output logic [RegWidth-1:0]     rf_wdata
);

   typedef enum logic {NORMAL, STALL} state_t;

   localparam logic [CNT_W-1:0] CntMax  = '1;
   localparam logic [CNT_W-1:0] LimitM1 = CNT_W'(STARVE_LIMIT - 1);

   state_t           state;
   logic             rr_ptr;
   logic [CNT_W-1:0] starve_cnt;

   logic wb_eff;
   logic a0_elig;
   logic a1_elig;
   logic a0_zero;
   logic a1_zero;
   logic grant0;
   logic grant1;
   logic pending;
   logic starved;

   assign wb_eff  = wb_we && (wb_waddr != '0);
   assign a0_elig = a0_valid && (a0_waddr != '0);
   assign a1_elig = a1_valid && (a1_waddr != '0);
   assign a0_zero = a0_valid && (a0_waddr == '0);
   assign a1_zero = a1_valid && (a1_waddr == '0);

   // rr_ptr only breaks ties; a lone eligible aux always takes a free slot
   assign grant0  = !wb_eff && a0_elig && (!a1_elig || !rr_ptr);
   assign grant1  = !wb_eff && a1_elig && (!a0_elig || rr_ptr);

   assign pending = a0_elig || a1_elig;
   assign starved = pending && !(grant0 || grant1);

   // Writes to $0 are acknowledged and discarded without using the slot
   assign a0_ready = rst && (grant0 || a0_zero);
   assign a1_ready = rst && (grant1 || a1_zero);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         rr_ptr     <= 1'b0;
         starve_cnt <= '0;
      end else begin
         if (wb_eff) begin
            rf_we    <= 1'b1;
            rf_waddr <= wb_waddr;
            rf_wdata <= wb_wdata;
         end else if (grant0) begin
            rf_we    <= 1'b1;
            rf_waddr <= a0_waddr;
            rf_wdata <= a0_wdata;
         end else if (grant1) begin
            rf_we    <= 1'b1;
            rf_waddr <= a1_waddr;
            rf_wdata <= a1_wdata;
         end else begin
            rf_we    <= 1'b0;
         end

         if (grant0) begin
            rr_ptr <= 1'b1;
         end else if (grant1) begin
            rr_ptr <= 1'b0;
         end

         if (!starved) begin
            starve_cnt <= '0;
         end else if (starve_cnt != CntMax) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= NORMAL;
         stall_req <= 1'b0;
      end else begin
         case (state)
            NORMAL: begin
               if (starved && (starve_cnt == LimitM1)) begin
                  state     <= STALL;
                  stall_req <= 1'b1;
               end
            end
            STALL: begin
               if (!starved) begin
                  state     <= NORMAL;
                  stall_req <= 1'b0;
               end
            end
            default: begin
               state     <= NORMAL;
               stall_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the write-port rules.
module tb_regfile_wport_arbiter;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wb_we = 1'b0;
   logic [AW-1:0] wb_waddr = '0;
   logic [DW-1:0] wb_wdata = '0;
   logic          a0_valid = 1'b0;
   logic [AW-1:0] a0_waddr = '0;
   logic [DW-1:0] a0_wdata = '0;
   logic          a0_ready;
   logic          a1_valid = 1'b0;
   logic [AW-1:0] a1_waddr = '0;
   logic [DW-1:0] a1_wdata = '0;
   logic          a1_ready;
   logic          stall_req;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   int errs   = 0;
   int checks = 0;

   // reference model state
   logic          m_rf_we;
   logic [AW-1:0] m_rf_waddr;
   logic [DW-1:0] m_rf_wdata;
   logic          m_stall;
   logic          m_prefer_a1;
   int            m_run;
   logic          m_wb, m_e0, m_e1, m_g0, m_g1, exp_r0, exp_r1;

   regfile_wport_arbiter #(
      .RegAddrWidth(AW), .RegWidth(DW), .STARVE_LIMIT(LIMIT), .CNT_W(3)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .a0_valid(a0_valid), .a0_waddr(a0_waddr), .a0_wdata(a0_wdata), .a0_ready(a0_ready),
      .a1_valid(a1_valid), .a1_waddr(a1_waddr), .a1_wdata(a1_wdata), .a1_ready(a1_ready),
      .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      wb_we = 1'b0; a0_valid = 1'b0; a1_valid = 1'b0;
      wb_waddr = '0; a0_waddr = '0; a1_waddr = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return '0;
      return AW'($urandom_range(1, 31));
   endfunction

   task automatic model_reset();
      m_rf_we = 1'b0; m_rf_waddr = '0; m_rf_wdata = '0;
      m_stall = 1'b0; m_prefer_a1 = 1'b0; m_run = 0;
   endtask

   // which requester owns this cycle's slot, and who sees ready
   task automatic model_eval();
      m_wb = wb_we && (wb_waddr != 0);
      m_e0 = a0_valid && (a0_waddr != 0);
      m_e1 = a1_valid && (a1_waddr != 0);
      m_g0 = 1'b0; m_g1 = 1'b0;
      if (!m_wb) begin
         if (m_e0 && m_e1) begin
            if (m_prefer_a1) m_g1 = 1'b1; else m_g0 = 1'b1;
         end else begin
            m_g0 = m_e0;
            m_g1 = m_e1;
         end
      end
      exp_r0 = m_g0 || (a0_valid && a0_waddr == 0);
      exp_r1 = m_g1 || (a1_valid && a1_waddr == 0);
   endtask

   // stall is owed once some aux has waited LIMIT consecutive cycles and still waits
   task automatic model_edge();
      logic waited;
      if (m_wb) begin
         m_rf_we = 1'b1; m_rf_waddr = wb_waddr; m_rf_wdata = wb_wdata;
      end else if (m_g0) begin
         m_rf_we = 1'b1; m_rf_waddr = a0_waddr; m_rf_wdata = a0_wdata; m_prefer_a1 = 1'b1;
      end else if (m_g1) begin
         m_rf_we = 1'b1; m_rf_waddr = a1_waddr; m_rf_wdata = a1_wdata; m_prefer_a1 = 1'b0;
      end else begin
         m_rf_we = 1'b0;
      end
      waited = (m_e0 || m_e1) && !(m_g0 || m_g1);
      m_run = waited ? m_run + 1 : 0;
      m_stall = waited && (m_run >= LIMIT);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      a0_valid = 1'b1; a0_waddr = '0; a1_valid = 1'b1; a1_waddr = 5'd3;
      #1;
      checks++;
      if ({a0_ready, a1_ready} !== 2'b00) begin
         errs++; $display("FAIL reset_ready got %b want 00", {a0_ready, a1_ready});
      end
      @(posedge clk); #1;
      checks++;
      if ({stall_req, rf_we, rf_waddr, rf_wdata} !== '0) begin
         errs++; $display("FAIL reset_outputs got stall=%b we=%b addr=%0d data=%h want all zero",
                          stall_req, rf_we, rf_waddr, rf_wdata);
      end
      apply_reset();
   endtask

   task automatic test_wb_only();
      apply_reset();
      wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h1234;
      #1;
      checks++;
      if ({a0_ready, a1_ready} !== 2'b00) begin
         errs++; $display("FAIL wb_only_ready got %b want 00", {a0_ready, a1_ready});
      end
      @(posedge clk); #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
         errs++; $display("FAIL wb_only_rf got we=%b addr=%0d data=%h want 1/5/1234", rf_we, rf_waddr, rf_wdata);
      end
      wb_we = 1'b0;
   endtask

   task automatic test_wb_vs_a0();
      apply_reset();
      wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h55;
      a0_valid = 1'b1; a0_waddr = 5'd7; a0_wdata = 32'hAA;
      #1;
      checks++;
      if (a0_ready !== 1'b0) begin
         errs++; $display("FAIL wb_vs_a0_blocked got a0_ready=%b want 0", a0_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h55}) begin
         errs++; $display("FAIL wb_vs_a0_wb got we=%b addr=%0d data=%h want 1/5/55", rf_we, rf_waddr, rf_wdata);
      end
      wb_we = 1'b0;
      #1;
      checks++;
      if (a0_ready !== 1'b1) begin
         errs++; $display("FAIL wb_vs_a0_grant got a0_ready=%b want 1", a0_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hAA}) begin
         errs++; $display("FAIL wb_vs_a0_aux got we=%b addr=%0d data=%h want 1/7/aa", rf_we, rf_waddr, rf_wdata);
      end
      a0_valid = 1'b0;
   endtask

   task automatic test_round_robin();
      apply_reset();
      a0_valid = 1'b1; a0_waddr = 5'd1; a0_wdata = 32'h11;
      a1_valid = 1'b1; a1_waddr = 5'd2; a1_wdata = 32'h22;
      for (int i = 0; i < 3; i++) begin
         logic [1:0]    want_rdy;
         logic [AW-1:0] want_addr;
         want_rdy  = (i % 2 == 0) ? 2'b10 : 2'b01;
         want_addr = (i % 2 == 0) ? 5'd1 : 5'd2;
         #1;
         checks++;
         if ({a0_ready, a1_ready} !== want_rdy) begin
            errs++; $display("FAIL rr_ready[%0d] got %b want %b", i, {a0_ready, a1_ready}, want_rdy);
         end
         @(posedge clk); #1;
         checks++;
         if ({rf_we, rf_waddr} !== {1'b1, want_addr}) begin
            errs++; $display("FAIL rr_addr[%0d] got we=%b addr=%0d want 1/%0d", i, rf_we, rf_waddr, want_addr);
         end
      end
      idle_inputs();
   endtask

   task automatic test_starvation();
      apply_reset();
      wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h99;
      a0_valid = 1'b1; a0_waddr = 5'd4; a0_wdata = 32'h44;
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++;
         if (a0_ready !== 1'b0) begin
            errs++; $display("FAIL starve_ready[%0d] got %b want 0", i, a0_ready);
         end
         @(posedge clk); #1;
         checks++;
         if (stall_req !== (i == 4)) begin
            errs++; $display("FAIL starve_stall[%0d] got %b want %b", i, stall_req, (i == 4));
         end
      end
      wb_we = 1'b0;
      #1;
      checks++;
      if (a0_ready !== 1'b1) begin
         errs++; $display("FAIL starve_release got a0_ready=%b want 1", a0_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({stall_req, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd4, 32'h44}) begin
         errs++; $display("FAIL starve_exit got stall=%b we=%b addr=%0d data=%h want 0/1/4/44",
                          stall_req, rf_we, rf_waddr, rf_wdata);
      end
      idle_inputs();
   endtask

   task automatic test_zero_addr();
      apply_reset();
      wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h33;
      a1_valid = 1'b1; a1_waddr = 5'd0; a1_wdata = 32'h99;
      #1;
      checks++;
      if ({a0_ready, a1_ready} !== 2'b01) begin
         errs++; $display("FAIL zero_a1_ack got %b want 01", {a0_ready, a1_ready});
      end
      @(posedge clk); #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h33}) begin
         errs++; $display("FAIL zero_a1_rf got we=%b addr=%0d data=%h want 1/3/33", rf_we, rf_waddr, rf_wdata);
      end
      wb_we = 1'b0;
      a0_valid = 1'b1; a0_waddr = 5'd1; a0_wdata = 32'h11;
      a1_valid = 1'b1; a1_waddr = 5'd2; a1_wdata = 32'h22;
      #1;
      checks++;
      if ({a0_ready, a1_ready} !== 2'b10) begin
         errs++; $display("FAIL zero_rr_kept got %b want 10", {a0_ready, a1_ready});
      end
      @(posedge clk); #1;
      wb_we = 1'b1; wb_waddr = 5'd6; wb_wdata = 32'h66;
      a0_waddr = 5'd0; a1_waddr = 5'd0;
      #1;
      checks++;
      if ({a0_ready, a1_ready} !== 2'b11) begin
         errs++; $display("FAIL zero_both_ack got %b want 11", {a0_ready, a1_ready});
      end
      @(posedge clk); #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'h66}) begin
         errs++; $display("FAIL zero_both_rf got we=%b addr=%0d data=%h want 1/6/66", rf_we, rf_waddr, rf_wdata);
      end
      wb_waddr = 5'd0;
      a0_waddr = 5'd8; a0_wdata = 32'h88; a1_valid = 1'b0;
      #1;
      checks++;
      if (a0_ready !== 1'b1) begin
         errs++; $display("FAIL zero_wb_frees got a0_ready=%b want 1", a0_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'h88}) begin
         errs++; $display("FAIL zero_wb_rf got we=%b addr=%0d data=%h want 1/8/88", rf_we, rf_waddr, rf_wdata);
      end
      idle_inputs();
      @(posedge clk); #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd8, 32'h88}) begin
         errs++; $display("FAIL idle_hold got we=%b addr=%0d data=%h want 0/8/88", rf_we, rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_reset_mid_stall();
      apply_reset();
      wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h99;
      a0_valid = 1'b1; a0_waddr = 5'd4; a0_wdata = 32'h44;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (stall_req !== 1'b1) begin
         errs++; $display("FAIL mid_stall_entered got %b want 1", stall_req);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({stall_req, rf_we, a0_ready, a1_ready, rf_waddr} !== '0) begin
         errs++; $display("FAIL mid_stall_async got stall=%b we=%b rdy=%b%b addr=%0d want all zero",
                          stall_req, rf_we, a0_ready, a1_ready, rf_waddr);
      end
      @(negedge clk) rst = 1'b1;
      wb_we = 1'b0;
      #1;
      checks++;
      if (a0_ready !== 1'b1) begin
         errs++; $display("FAIL post_reset_grant got a0_ready=%b want 1", a0_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({stall_req, rf_we, rf_waddr} !== {1'b0, 1'b1, 5'd4}) begin
         errs++; $display("FAIL post_reset_rf got stall=%b we=%b addr=%0d want 0/1/4", stall_req, rf_we, rf_waddr);
      end
      wb_we = 1'b1; a0_waddr = 5'd5;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (stall_req !== (i == 4)) begin
            errs++; $display("FAIL restart_stall[%0d] got %b want %b", i, stall_req, (i == 4));
         end
      end
      idle_inputs();
      @(posedge clk); #1;
      checks++;
      if (stall_req !== 1'b0) begin
         errs++; $display("FAIL withdraw_stall got %b want 0", stall_req);
      end
   endtask

   task automatic test_random();
      logic p0, p1;
      int   wb_pct;
      apply_reset();
      model_reset();
      p0 = 1'b0; p1 = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         wb_pct   = ((cyc / 32) % 2 == 0) ? 90 : 30;
         wb_we    = ($urandom_range(0, 99) < wb_pct);
         wb_waddr = rand_addr();
         wb_wdata = $urandom;
         if (!(a0_valid && !p0 && ($urandom_range(0, 9) < 8))) begin
            a0_valid = ($urandom_range(0, 9) < 6);
            a0_waddr = rand_addr();
            a0_wdata = $urandom;
         end
         if (!(a1_valid && !p1 && ($urandom_range(0, 9) < 8))) begin
            a1_valid = ($urandom_range(0, 9) < 6);
            a1_waddr = rand_addr();
            a1_wdata = $urandom;
         end
         #1;
         model_eval();
         checks++;
         if ({a0_ready, a1_ready} !== {exp_r0, exp_r1}) begin
            errs++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, {a0_ready, a1_ready}, {exp_r0, exp_r1});
         end
         p0 = exp_r0; p1 = exp_r1;
         @(posedge clk);
         model_edge();
         #1;
         checks++;
         if ({stall_req, rf_we, rf_waddr, rf_wdata} !== {m_stall, m_rf_we, m_rf_waddr, m_rf_wdata}) begin
            errs++; $display("FAIL rand_regs cyc=%0d got stall=%b we=%b addr=%0d data=%h want stall=%b we=%b addr=%0d data=%h",
                             cyc, stall_req, rf_we, rf_waddr, rf_wdata, m_stall, m_rf_we, m_rf_waddr, m_rf_wdata);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_wb_only();
      test_wb_vs_a0();
      test_round_robin();
      test_starvation();
      test_zero_addr();
      test_reset_mid_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
